// File: rtl/exp_pkg.sv
// Shared types and helpers for the fixed-point Taylor-series exponential unit.
// Internal saturation math is done at SAT_W bits, so WIDTH may be at most 64.
package exp_pkg;

    typedef enum logic [1:0] {IDLE, MULX, MULK, DONE} state_e;

    localparam int SAT_W = 128;

    // floor(2^frac / k); entry 0 is unused and returns 0.
    function automatic logic [63:0] inv_val(input int k, input int frac);
        if (k <= 0) begin
            return 64'd0;
        end
        return (64'd1 << frac) / 64'(k);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                       input int w,
                                                       output logic ovf);
        logic signed [SAT_W-1:0] one, hi, lo;
        one = 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        ovf = (v > hi) || (v < lo);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply: full-width product, floor shift by FRAC, saturate to WIDTH.
module fx_mul_sat
    import exp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;

    assign prod    = a * b;
    assign shifted = prod >>> FRAC;

    always_comb begin
        ovf = 1'b0;
        p   = WIDTH'(sat_to(SAT_W'(shifted), WIDTH, ovf));
    end

endmodule

// File: rtl/exp_taylor_fx.sv
// Iterative e^x as a truncated Taylor series; one shared multiplier alternates between
// term*x and term*(1/k), with a saturating accumulator and a sticky overflow flag.
module exp_taylor_fx
    import exp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TERMS = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int KW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(64'd1 << FRAC);

    state_e                   state;
    logic signed [WIDTH-1:0]  x, term, acc;
    logic [KW-1:0]            k;
    logic                     ovf;

    logic signed [WIDTH-1:0]  inv_tbl [TERMS];
    logic signed [WIDTH-1:0]  mul_b, mul_p, acc_sum;
    logic                     mul_ovf, add_ovf;

    for (genvar g = 0; g < TERMS; g++) begin : g_inv
        assign inv_tbl[g] = WIDTH'(inv_val(g, FRAC));
    end

    assign mul_b = (state == MULX) ? x : inv_tbl[k];

    fx_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .a   (term),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    always_comb begin
        add_ovf = 1'b0;
        acc_sum = WIDTH'(sat_to(SAT_W'(acc) + SAT_W'(mul_p), WIDTH, add_ovf));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            x         <= '0;
            term      <= '0;
            acc       <= '0;
            k         <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x        <= in_data;
                        term     <= ONE;
                        acc      <= ONE;
                        k        <= KW'(1);
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= (TERMS == 1) ? DONE : MULX;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MULX: begin
                    term  <= mul_p;
                    ovf   <= ovf | mul_ovf;
                    state <= MULK;
                end
                MULK: begin
                    term <= mul_p;
                    acc  <= acc_sum;
                    ovf  <= ovf | mul_ovf | add_ovf;
                    if (k == KW'(TERMS - 1)) begin
                        state <= DONE;
                    end else begin
                        k     <= k + KW'(1);
                        state <= MULX;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; later cycles wait for out_ready.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_ovf   <= ovf;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
